// File: rtl/i2c_state_pkg.sv
// Shared types and defaults for the I2C memory datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_state_pkg;

   localparam int I2C_MEM_ADDR_W = 8;
   localparam int I2C_MEM_DATA_W = 8;

   // Latency counter is wide enough for read latencies 1..4.
   localparam int RD_CNT_W = 2;

   // One-hot bit positions of the read prefetch state.
   localparam int RD_IDLE_BIT  = 0;
   localparam int RD_ISSUE_BIT = 1;
   localparam int RD_WAIT_BIT  = 2;
   localparam int RD_VALID_BIT = 3;

   typedef enum logic [3:0] {
      RD_IDLE  = 4'b0001,
      RD_ISSUE = 4'b0010,
      RD_WAIT  = 4'b0100,
      RD_VALID = 4'b1000
   } rd_state_t;

endpackage

// File: rtl/i2c_mem_rd_prefetch.sv
// Read prefetch: on a read_mem rising edge fetch one RAM byte into tx_byte for the transmit shifter.
// Latency: tx_byte_valid rises RAM_RD_LAT+1 cycles after the read_mem rising edge.
// Backpressure: none; a falling read_mem aborts the fetch or ends the valid window.
module i2c_mem_rd_prefetch
   import i2c_state_pkg::*;
#(
   parameter int DATA_W     = I2C_MEM_DATA_W,
   parameter int RAM_RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              read_mem_i,
   input  logic              block_i,
   input  logic [DATA_W-1:0] ram_rdata_i,
   output logic              ram_rden_o,
   output logic [DATA_W-1:0] tx_byte_o,
   output logic              tx_byte_valid_o
);

   rd_state_t           state_q, state_d;
   logic [RD_CNT_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic                read_mem_q;
   logic                read_mem_rise;

   assign read_mem_rise = read_mem_i & ~read_mem_q;

   // Next-state: issue, wait out the RAM latency, then hold the byte while the master reads.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tx_d    = tx_q;
      if (clear_i) begin
         state_d = RD_IDLE;
      end else begin
         case (state_q)
            RD_IDLE: begin
               if (read_mem_rise && !block_i) state_d = RD_ISSUE;
            end
            RD_ISSUE: begin
               if (!read_mem_i) begin
                  state_d = RD_IDLE;
               end else begin
                  cnt_d   = RD_CNT_W'(RAM_RD_LAT - 1);
                  state_d = RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (!read_mem_i) begin
                  state_d = RD_IDLE;
               end else if (cnt_q == '0) begin
                  tx_d    = ram_rdata_i;
                  state_d = RD_VALID;
               end else begin
                  cnt_d = cnt_q - RD_CNT_W'(1);
               end
            end
            RD_VALID: begin
               if (!read_mem_i) state_d = RD_IDLE;
            end
            default: state_d = RD_IDLE;
         endcase
      end
   end

   // State, counter, byte and edge-detect registers; a clear forgets the previous read_mem level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RD_IDLE;
         cnt_q      <= '0;
         tx_q       <= '0;
         read_mem_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tx_q       <= tx_d;
         read_mem_q <= clear_i ? 1'b0 : read_mem_i;
      end
   end

   assign ram_rden_o      = state_q[RD_ISSUE_BIT];
   assign tx_byte_valid_o = state_q[RD_VALID_BIT];
   assign tx_byte_o       = tx_q;

endmodule

// File: rtl/i2c_mem_datapath.sv
// Memory-side datapath: address pointer, write path, read prefetch and sticky mem_nack.
// Latency: pointer/data capture 1 cycle, ram_wren 1 cycle after wren rises, read data RAM_RD_LAT+1.
// Backpressure: none; out-of-range pointer raises mem_nack. Option: I2C_MEM_ADDR_WRAP_EN (pointer wrap).
module i2c_mem_datapath
   import i2c_state_pkg::*;
#(
   parameter int ADDR_W     = I2C_MEM_ADDR_W,
   parameter int DATA_W     = I2C_MEM_DATA_W,
   parameter int DEPTH      = 256,
   parameter int RAM_RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i2c_wait,
   input  logic [DATA_W-1:0] rx_byte,
   input  logic              rx_byte_valid,
   input  logic              read_mem_address,
   input  logic              write_mem,
   input  logic              wren,
   input  logic              increment_mem_address,
   input  logic              read_mem,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_wren,
   output logic              ram_rden,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] tx_byte,
   output logic              tx_byte_valid,
   output logic              mem_nack
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              nack_q, nack_d;
   logic              wren_q, wren_d;
   logic              wr_pulse_q, wr_pulse_d;
   logic              rx_oor;
   logic              at_end;

   assign rx_oor = (32'(rx_byte) >= 32'(DEPTH));
   assign at_end = (32'(addr_q) == 32'(DEPTH - 1));

   // Pointer, write data and nack next-state; i2c_wait beats address capture beats increment.
   always_comb begin
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      nack_d     = nack_q;
      wren_d     = wren & ~i2c_wait;
      wr_pulse_d = wren & ~wren_q & ~nack_q & ~i2c_wait;
      if (i2c_wait) begin
         nack_d = 1'b0;
      end else if (rx_byte_valid && read_mem_address) begin
         addr_d = rx_byte[ADDR_W-1:0];
         if (rx_oor) nack_d = 1'b1;
      end else if (increment_mem_address) begin
         if (at_end) begin
`ifdef I2C_MEM_ADDR_WRAP_EN
            addr_d = '0;
`else
            nack_d = 1'b1;
`endif
         end else begin
            addr_d = addr_q + ADDR_W'(1);
         end
      end
      if (rx_byte_valid && write_mem) wdata_d = rx_byte;
   end

   // Datapath registers; the write strobe is a registered rising edge of wren.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         nack_q     <= 1'b0;
         wren_q     <= 1'b0;
         wr_pulse_q <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         nack_q     <= nack_d;
         wren_q     <= wren_d;
         wr_pulse_q <= wr_pulse_d;
      end
   end

   i2c_mem_rd_prefetch #(
      .DATA_W     (DATA_W),
      .RAM_RD_LAT (RAM_RD_LAT)
   ) u_rd_prefetch (
      .clk             (clk),
      .rst_n           (rst_n),
      .clear_i         (i2c_wait),
      .read_mem_i      (read_mem),
      .block_i         (nack_q),
      .ram_rdata_i     (ram_rdata),
      .ram_rden_o      (ram_rden),
      .tx_byte_o       (tx_byte),
      .tx_byte_valid_o (tx_byte_valid)
   );

   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign ram_wren  = wr_pulse_q;
   assign mem_nack  = nack_q;

endmodule

// File: tb/tb_i2c_mem_datapath.sv
// Bench for i2c_mem_datapath: directed scenarios plus random traffic against a window-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_mem_datapath;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 128;
   localparam int LAT    = 2;

   logic             clk;
   logic             rst_n;
   logic             i2c_wait, rx_byte_valid, read_mem_address, write_mem, wren;
   logic             increment_mem_address, read_mem;
   logic [DATA_W-1:0] rx_byte;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata, tx_byte;
   logic             ram_wren, ram_rden, tx_byte_valid, mem_nack;

   int checks = 0;
   int errors = 0;
   logic first_reset = 1'b1;

   i2c_mem_datapath #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RAM_RD_LAT(LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i2c_wait(i2c_wait), .rx_byte(rx_byte),
      .rx_byte_valid(rx_byte_valid), .read_mem_address(read_mem_address),
      .write_mem(write_mem), .wren(wren), .increment_mem_address(increment_mem_address),
      .read_mem(read_mem), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
      .ram_rden(ram_rden), .ram_rdata(ram_rdata), .tx_byte(tx_byte),
      .tx_byte_valid(tx_byte_valid), .mem_nack(mem_nack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ramval(input int i);
      case (i)
         32'h20:  return 8'h3C;
         32'h21:  return 8'hC3;
         32'h30:  return 8'h77;
         default: return 8'((i * 7 + 1) & 255);
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Registered RAM with LAT-cycle read pipeline; data held between fetches.
   logic [7:0] ram [256];
   logic [7:0] rd_pipe [LAT];
   assign ram_rdata = rd_pipe[LAT-1];
   always @(posedge clk) begin
      if (first_reset) begin
         for (int i = 0; i < 256; i++) ram[i] <= ramval(i);
         for (int i = 0; i < LAT; i++) rd_pipe[i] <= 8'h00;
      end else begin
         if (ram_rden) rd_pipe[0] <= ram[ram_addr];
         for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
         if (ram_wren) ram[ram_addr] <= ram_wdata;
      end
   end

   // Behavioural model: pointer/nack rules, one write per wren rise, and a fetch window per read_mem rise.
   logic [7:0] m_mem [256];
   logic [7:0] m_addr, m_wdata, m_tx, m_fetch;
   logic       m_nack, m_valid, m_rden, m_wpulse, m_rm_prev, m_wren_prev;
   int         m_remain;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if (first_reset) for (int i = 0; i < 256; i++) m_mem[i] = ramval(i);
         m_addr = 0; m_wdata = 0; m_tx = 0; m_fetch = 0;
         m_nack = 0; m_valid = 0; m_rden = 0; m_wpulse = 0;
         m_rm_prev = 0; m_wren_prev = 0; m_remain = 0;
      end else begin
         if (m_rden) m_fetch = m_mem[m_addr];
         if (m_wpulse) m_mem[m_addr] = m_wdata;
         if (i2c_wait) begin
            m_nack = 0; m_valid = 0; m_rden = 0; m_remain = 0;
            m_rm_prev = 0; m_wren_prev = 0; m_wpulse = 0;
         end else begin
            m_wpulse = wren && !m_wren_prev && !m_nack;
            m_wren_prev = wren;
            if (!read_mem) begin
               m_rden = 0; m_remain = 0; m_valid = 0;
            end else if (m_rden) begin
               m_rden = 0; m_remain = LAT;
            end else if (m_remain > 0) begin
               m_remain--;
               if (m_remain == 0) begin m_valid = 1; m_tx = m_fetch; end
            end else if (!m_rm_prev && !m_nack) begin
               m_rden = 1;
            end
            m_rm_prev = read_mem;
            if (rx_byte_valid && read_mem_address) begin
               m_addr = rx_byte;
               if (int'(rx_byte) >= DEPTH) m_nack = 1;
            end else if (increment_mem_address) begin
               if (int'(m_addr) == DEPTH - 1) begin
`ifdef I2C_MEM_ADDR_WRAP_EN
                  m_addr = 0;
`else
                  m_nack = 1;
`endif
               end else begin
                  m_addr = m_addr + 8'd1;
               end
            end
         end
         if (rx_byte_valid && write_mem) m_wdata = rx_byte;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(posedge clk) begin
      #2;
      chk("ram_addr", ram_addr, m_addr);
      chk("ram_wdata", ram_wdata, m_wdata);
      chk("ram_wren", ram_wren, m_wpulse);
      chk("ram_rden", ram_rden, m_rden);
      chk("tx_byte_valid", tx_byte_valid, m_valid);
      chk("tx_byte", tx_byte, m_tx);
      chk("mem_nack", mem_nack, m_nack);
   end

   task automatic send_addr(input logic [7:0] b);
      rx_byte = b; rx_byte_valid = 1; read_mem_address = 1;
      @(negedge clk);
      rx_byte_valid = 0; read_mem_address = 0;
   endtask

   task automatic send_data(input logic [7:0] b);
      rx_byte = b; rx_byte_valid = 1; write_mem = 1;
      @(negedge clk);
      rx_byte_valid = 0; write_mem = 0;
   endtask

   task automatic pulse_wait();
      i2c_wait = 1; @(negedge clk); i2c_wait = 0;
   endtask

   task automatic pulse_incr();
      increment_mem_address = 1; @(negedge clk); increment_mem_address = 0;
   endtask

   initial begin
      int n;
      rst_n = 0; i2c_wait = 0; rx_byte = 0; rx_byte_valid = 0; read_mem_address = 0;
      write_mem = 0; wren = 0; increment_mem_address = 0; read_mem = 0;
      repeat (3) @(negedge clk);
      chk("rst_addr", ram_addr, 0);
      chk("rst_wren", ram_wren, 0);
      chk("rst_rden", ram_rden, 0);
      chk("rst_tx", tx_byte, 0);
      chk("rst_valid", tx_byte_valid, 0);
      chk("rst_nack", mem_nack, 0);
      rst_n = 1; first_reset = 0;
      @(negedge clk);

      // 1: address + data capture, long wren gives one write pulse
      send_addr(8'h10);
      send_data(8'hA5);
      wren = 1; n = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n += int'(ram_wren);
         if (i == 3) wren = 0;
      end
      chk("t1_wren_pulses", n, 1);
      chk("t1_addr", ram_addr, 8'h10);
      chk("t1_wdata", ram_wdata, 8'hA5);
      chk("t1_ram", ram[8'h10], 8'hA5);

      // 2: fetch with two-cycle RAM latency, then increment and fetch next
      send_addr(8'h20);
      read_mem = 1;
      @(negedge clk); chk("t2_rden_issue", ram_rden, 1);
      @(negedge clk); chk("t2_rden_once", ram_rden, 0);
      @(negedge clk); chk("t2_valid_early", tx_byte_valid, 0);
      @(negedge clk); chk("t2_valid", tx_byte_valid, 1);
      chk("t2_tx", tx_byte, 8'h3C);
      read_mem = 0;
      pulse_incr();
      chk("t2_incr", ram_addr, 8'h21);
      read_mem = 1;
      repeat (4) @(negedge clk);
      chk("t2_valid2", tx_byte_valid, 1);
      chk("t2_tx2", tx_byte, 8'hC3);
      read_mem = 0;
      @(negedge clk);

      // 3: out-of-range address sets nack and blocks fetches
      send_addr(8'h90);
      chk("t3_nack", mem_nack, 1);
      chk("t3_addr", ram_addr, 8'h90);
      read_mem = 1; n = 0;
      repeat (5) begin @(negedge clk); n += int'(ram_rden); end
      chk("t3_no_rden", n, 0);
      chk("t3_no_valid", tx_byte_valid, 0);
      read_mem = 0;
      @(negedge clk);

      // 4: increment at the last location
      pulse_wait();
      chk("t4_nack_clr", mem_nack, 0);
      send_addr(8'(DEPTH - 1));
      pulse_incr();
`ifdef I2C_MEM_ADDR_WRAP_EN
      chk("t4_addr", ram_addr, 8'h00);
      chk("t4_nack", mem_nack, 0);
`else
      chk("t4_addr", ram_addr, 8'h7F);
      chk("t4_nack", mem_nack, 1);
`endif

      // 5: read_mem drops during the latency wait
      pulse_wait();
      send_addr(8'h30);
      read_mem = 1;
      repeat (2) @(negedge clk);
      read_mem = 0; n = 0;
      repeat (3) begin @(negedge clk); n += int'(tx_byte_valid); end
      chk("t5_valid_cnt", n, 0);
      chk("t5_tx_kept", tx_byte, 8'hC3);

      // 6: i2c_wait in the valid window with nack set; then reset during wren
      read_mem = 1;
      repeat (4) @(negedge clk);
      chk("t6_valid", tx_byte_valid, 1);
      chk("t6_tx", tx_byte, 8'h77);
      send_addr(8'h90);
      chk("t6_nack_set", mem_nack, 1);
      pulse_wait();
      chk("t6_valid_clr", tx_byte_valid, 0);
      chk("t6_nack_clr", mem_nack, 0);
      chk("t6_addr_kept", ram_addr, 8'h90);
      read_mem = 0;
      repeat (4) @(negedge clk);
      wren = 1;
      #2 rst_n = 0;
      n = 0;
      repeat (3) begin @(negedge clk); n += int'(ram_wren); end
      wren = 0; rst_n = 1;
      repeat (2) begin @(negedge clk); n += int'(ram_wren); end
      chk("t6_rst_no_wren", n, 0);
      chk("t6_rst_addr", ram_addr, 0);
      chk("t6_rst_tx", tx_byte, 0);

      // random traffic, checked every cycle by the compare process
      for (int c = 0; c < 3000; c++) begin
         rx_byte_valid = ($urandom_range(3) == 0);
         rx_byte = 8'($urandom);
         read_mem_address = ($urandom_range(2) == 0);
         write_mem = ($urandom_range(1) == 0);
         increment_mem_address = ($urandom_range(7) == 0);
         i2c_wait = ($urandom_range(39) == 0);
         if ($urandom_range(7) == 0) read_mem = ~read_mem;
         if ($urandom_range(4) == 0) wren = ~wren;
         @(negedge clk);
      end
      rx_byte_valid = 0; read_mem_address = 0; write_mem = 0; increment_mem_address = 0;
      i2c_wait = 0; read_mem = 0; wren = 0;
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
